stereo_match_tm: RTL and testbench

- Time-multiplexed census stereo matcher, successor to the fully parallel D-lane matcher.
- Consumes pre-computed left/right census codes, one pixel pair per handshake, and evaluates D disparity candidates with P Hamming lanes over D/P cycles.
- Produces a winner-take-all disparity plus a uniqueness-based confidence flag, replacing the area-heavy left-right consistency path.
- Sits between census_transform and downstream disparity filtering.

---
 rtl/stereo_tm_pkg.sv | 16 +
 rtl/census_hamming.sv | 23 ++
 rtl/stereo_match_tm.sv | 140 ++++++++++++++
 tb/tb_stereo_match_tm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stereo_tm_pkg.sv
// Shared types and width helpers for the time-multiplexed census stereo matcher.
package stereo_tm_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StEmit} state_t;

   localparam int unsigned COST_MAX = 24;

   function automatic int unsigned disp_bits(input int unsigned d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

   function automatic int unsigned cost_bits(input int unsigned cw);
      return $clog2(cw + 1);
   endfunction

endpackage

// File: rtl/census_hamming.sv
// Hamming distance between two census codes: XOR followed by popcount.
module census_hamming
   import stereo_tm_pkg::*;
#(
   parameter int unsigned CW = COST_MAX,
   localparam int unsigned CBIT = cost_bits(CW)
) (
   input  logic [CW-1:0]   code_a,
   input  logic [CW-1:0]   code_b,
   output logic [CBIT-1:0] cost
);

   logic [CW-1:0] diff;

   always_comb begin
      diff = code_a ^ code_b;
      cost = '0;
      for (int i = 0; i < CW; i++) begin
         cost = cost + CBIT'(diff[i]);
      end
   end

endmodule

// File: rtl/stereo_match_tm.sv
// Census stereo matcher: scans D disparities with P Hamming lanes over D/P cycles,
// emits a winner-take-all disparity and a uniqueness-based confidence flag.
module stereo_match_tm
   import stereo_tm_pkg::*;
#(
   parameter int unsigned D = 64,
   parameter int unsigned P = 8,
   parameter int unsigned CW = COST_MAX,
   localparam int unsigned DBIT = disp_bits(D),
   localparam int unsigned CBIT = cost_bits(CW)
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [CW-1:0]   i_code_l,
   input  logic [CW-1:0]   i_code_r,
   input  logic            i_dval,
   input  logic            i_eol,
   input  logic [CBIT-1:0] i_uniq_margin,
   output logic            o_ready,
   output logic            o_dval,
   output logic [DBIT-1:0] o_data,
   output logic            o_conf
);

   localparam int unsigned K = D / P;
   localparam int unsigned KBIT = (K > 1) ? $clog2(K) : 1;

   state_t state_q, state_d;

   logic [CW-1:0]   code_l_q;
   logic [CBIT-1:0] margin_q;
   logic [CW-1:0]   rbuf_q [D];
   logic [DBIT-1:0] col_q;
   logic [DBIT-1:0] pix_col_q;
   logic [KBIT-1:0] k_q;
   logic [CBIT-1:0] best_q, second_q;
   logic [DBIT-1:0] best_d_q;

   logic [CBIT-1:0] best_n, second_n;
   logic [DBIT-1:0] best_d_n;
   logic [CBIT-1:0] lane_cost [P];
   logic [DBIT-1:0] lane_d [P];
   logic [CBIT:0]   gap;
   logic            conf;
   logic            accept;

   assign o_ready = (state_q == StIdle);
   assign accept  = i_dval & o_ready;

   for (genvar j = 0; j < P; j++) begin : g_lane
      assign lane_d[j] = DBIT'(int'(k_q) * int'(P) + j);
      census_hamming #(.CW(CW)) u_ham (
         .code_a (code_l_q),
         .code_b (rbuf_q[lane_d[j]]),
         .cost   (lane_cost[j])
      );
   end

   // Lanes fold in ascending d so ties keep the lower disparity.
   always_comb begin
      best_n   = best_q;
      second_n = second_q;
      best_d_n = best_d_q;
      for (int j = 0; j < P; j++) begin
         if (lane_d[j] <= pix_col_q) begin
            if (lane_cost[j] < best_n) begin
               second_n = best_n;
               best_n   = lane_cost[j];
               best_d_n = lane_d[j];
            end else if (lane_cost[j] < second_n) begin
               second_n = lane_cost[j];
            end
         end
      end
   end

   assign gap  = {1'b0, second_q} - {1'b0, best_q};
   assign conf = (gap >= {1'b0, margin_q});

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_dval) state_d = StScan;
         StScan:  if (k_q == KBIT'(K - 1)) state_d = StEmit;
         StEmit:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= StIdle;
         code_l_q  <= '0;
         margin_q  <= '0;
         col_q     <= '0;
         pix_col_q <= '0;
         k_q       <= '0;
         best_q    <= '0;
         second_q  <= '0;
         best_d_q  <= '0;
         o_dval    <= 1'b0;
         o_data    <= '0;
         o_conf    <= 1'b0;
         for (int d = 0; d < D; d++) rbuf_q[d] <= '0;
      end else begin
         state_q <= state_d;
         o_dval  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  code_l_q  <= i_code_l;
                  margin_q  <= i_uniq_margin;
                  rbuf_q[0] <= i_code_r;
                  for (int d = 1; d < D; d++) rbuf_q[d] <= rbuf_q[d-1];
                  best_q    <= CBIT'(CW);
                  second_q  <= CBIT'(CW);
                  best_d_q  <= '0;
                  k_q       <= '0;
                  pix_col_q <= col_q;
                  if (i_eol) col_q <= '0;
                  else if (col_q != DBIT'(D - 1)) col_q <= col_q + DBIT'(1);
               end
            end
            StScan: begin
               best_q   <= best_n;
               second_q <= second_n;
               best_d_q <= best_d_n;
               k_q      <= k_q + KBIT'(1);
            end
            StEmit: begin
               o_dval <= 1'b1;
               o_data <= best_d_q;
               o_conf <= conf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stereo_match_tm.sv
// Directed bench for stereo_match_tm: a CW=24 DUT plus a CW=23 twin sharing stimulus.
module tb_stereo_match_tm;

   localparam logic [23:0] L = 24'hAAAAAA;
   localparam logic [23:0] F = 24'hAAAA95;  // 6 bits away from L

   logic        clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic [23:0] i_code_l = '0;
   logic [23:0] i_code_r = '0;
   logic        i_dval = 1'b0;
   logic        i_eol = 1'b0;
   logic [4:0]  i_uniq_margin = '0;
   logic        o_ready, o_dval, o_conf;
   logic [5:0]  o_data;
   logic        o_ready23, o_dval23, o_conf23;
   logic [5:0]  o_data23;

   int checks = 0;
   int errors = 0;
   int lat;
   int nstrobe;
   int pos [3];
   logic       got;
   logic [5:0] res_data, res_data23;
   logic       res_conf, res_conf23, res_ready;

   always #5 clk = ~clk;

   stereo_match_tm #(.D(64), .P(8), .CW(24)) u_dut (
      .i_clk         (clk),
      .i_rstn        (i_rstn),
      .i_code_l      (i_code_l),
      .i_code_r      (i_code_r),
      .i_dval        (i_dval),
      .i_eol         (i_eol),
      .i_uniq_margin (i_uniq_margin),
      .o_ready       (o_ready),
      .o_dval        (o_dval),
      .o_data        (o_data),
      .o_conf        (o_conf)
   );

   stereo_match_tm #(.D(64), .P(8), .CW(23)) u_dut23 (
      .i_clk         (clk),
      .i_rstn        (i_rstn),
      .i_code_l      (i_code_l[22:0]),
      .i_code_r      (i_code_r[22:0]),
      .i_dval        (i_dval),
      .i_eol         (i_eol),
      .i_uniq_margin (i_uniq_margin),
      .o_ready       (o_ready23),
      .o_dval        (o_dval23),
      .o_data        (o_data23),
      .o_conf        (o_conf23)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one pixel while idle and wait (bounded) for its result strobe.
   task automatic pixel(input logic [23:0] l, input logic [23:0] r, input logic eol,
                        input logic [4:0] m);
      chk("ready_before", 32'(o_ready), 32'd1);
      i_code_l = l;
      i_code_r = r;
      i_eol = eol;
      i_uniq_margin = m;
      i_dval = 1'b1;
      tick();
      i_dval = 1'b0;
      i_eol = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20 && !got; n++) begin
         tick();
         if (o_dval) begin
            got = 1'b1;
            lat = n;
            res_data = o_data;
            res_conf = o_conf;
            res_ready = o_ready;
            res_data23 = o_data23;
            res_conf23 = o_conf23;
         end
      end
      chk("strobe_seen", 32'(got), 32'd1);
      if (got) begin
         chk("latency", 32'(lat), 32'd9);
         chk("ready_at_strobe", 32'(res_ready), 32'd1);
      end
   endtask

   initial begin
      // Reset with random valid traffic
      for (int i = 0; i < 3; i++) begin
         i_dval = 1'($urandom_range(0, 1));
         i_code_l = 24'($urandom);
         i_code_r = 24'($urandom);
         tick();
         chk("rst_dval", 32'(o_dval), 32'd0);
         chk("rst_data", 32'(o_data), 32'd0);
         chk("rst_conf", 32'(o_conf), 32'd0);
      end
      i_dval = 1'b0;
      i_rstn = 1'b1;
      tick();
      chk("ready_after_rst", 32'(o_ready), 32'd1);
      nstrobe = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (o_dval) nstrobe++;
      end
      chk("no_output_from_rst", 32'(nstrobe), 32'd0);

      // Pixels 0..10 build history; L lands at pixel 6
      for (int p = 0; p <= 10; p++) begin
         pixel(L, (p == 6) ? L : F, 1'b0, 5'd0);
         if (p == 0) begin
            tick();
            chk("strobe_one_cycle", 32'(o_dval), 32'd0);
         end
      end
      pixel(L, F, 1'b0, 5'd4);
      chk("match_data", 32'(res_data), 32'd5);
      chk("match_conf_m4", 32'(res_conf), 32'd1);
      pixel(L, F, 1'b0, 5'd7);
      chk("match_data_shift", 32'(res_data), 32'd6);
      chk("match_conf_m7", 32'(res_conf), 32'd0);

      // Tie: cost 0 at d=3 and d=7 for pixel 20
      for (int p = 13; p <= 19; p++) pixel(L, (p == 13 || p == 17) ? L : F, 1'b0, 5'd0);
      pixel(L, F, 1'b0, 5'd1);
      chk("tie_data", 32'(res_data), 32'd3);
      chk("tie_conf_m1", 32'(res_conf), 32'd0);
      pixel(L, F, 1'b0, 5'd0);
      chk("tie_data_shift", 32'(res_data), 32'd4);
      chk("tie_conf_m0", 32'(res_conf), 32'd1);

      // Valid held high: accepts at edges 0, 10, 20 -> strobes after edges 9, 19, 29
      i_code_l = L;
      i_code_r = F;
      i_uniq_margin = 5'd0;
      i_dval = 1'b1;
      nstrobe = 0;
      for (int n = 0; n <= 29; n++) begin
         tick();
         if (o_dval) begin
            if (nstrobe < 3) pos[nstrobe] = n;
            nstrobe++;
         end
         if (n == 29) i_dval = 1'b0;
      end
      chk("tput_count", 32'(nstrobe), 32'd3);
      chk("tput_pos0", 32'(pos[0]), 32'd9);
      chk("tput_pos1", 32'(pos[1]), 32'd19);
      chk("tput_pos2", 32'(pos[2]), 32'd29);
      tick();
      chk("tput_ready", 32'(o_ready), 32'd1);

      // Line start, margin boundary on both code widths, masking of stale entry
      pixel(L, F, 1'b1, 5'd0);
      pixel(L, L, 1'b1, 5'd24);
      chk("col0_data", 32'(res_data), 32'd0);
      chk("col0_conf_m24", 32'(res_conf), 32'd1);
      chk("col0_data_cw23", 32'(res_data23), 32'd0);
      chk("col0_conf_cw23_m24", 32'(res_conf23), 32'd0);
      pixel(L, F, 1'b0, 5'd18);
      chk("col0b_data", 32'(res_data), 32'd0);
      chk("col0b_conf_m18", 32'(res_conf), 32'd1);
      chk("col0b_conf_cw23_m18", 32'(res_conf23), 32'd0);
      pixel(L, F, 1'b0, 5'd0);
      pixel(L, F, 1'b0, 5'd0);
      chk("mask_col2_data", 32'(res_data), 32'd0);
      chk("mask_col2_conf", 32'(res_conf), 32'd1);

      // Reset asserted at scan edge 4
      i_code_l = L;
      i_code_r = L;
      i_uniq_margin = 5'd0;
      i_dval = 1'b1;
      tick();
      i_dval = 1'b0;
      chk("busy_after_accept", 32'(o_ready), 32'd0);
      tick();
      tick();
      tick();
      i_rstn = 1'b0;
      tick();
      i_rstn = 1'b1;
      chk("midrst_data", 32'(o_data), 32'd0);
      chk("midrst_conf", 32'(o_conf), 32'd0);
      nstrobe = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_dval) nstrobe++;
      end
      chk("midrst_no_strobe", 32'(nstrobe), 32'd0);
      pixel(L, L, 1'b0, 5'd24);
      chk("post_rst_data", 32'(res_data), 32'd0);
      chk("post_rst_col0_conf", 32'(res_conf), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
